// File: rtl/dap_pkg.sv
// Shared DAP definitions: shifter FSM states, line direction codes and default transfer width.
package dap_pkg;

   localparam int DEFAULT_MAX_BITS = 32;

   localparam logic DIR_IN  = 1'b0;
   localparam logic DIR_OUT = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

endpackage

// File: rtl/dap_bit_shifter_if.sv
// Command/response handshake between a DAP sequencer (master) and the bit shifter (slave).
interface dap_bit_shifter_if import dap_pkg::*; #(
   parameter int MAX_BITS = DEFAULT_MAX_BITS,
   parameter int CNT_W    = $clog2(MAX_BITS + 1)
) ();

   logic                cmd_valid;
   logic                cmd_ready;
   logic                cmd_dir;
   logic [CNT_W-1:0]    cmd_len;
   logic [MAX_BITS-1:0] cmd_wdata;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [MAX_BITS-1:0] rsp_rdata;

   modport master (
      output cmd_valid, cmd_dir, cmd_len, cmd_wdata, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  cmd_valid, cmd_dir, cmd_len, cmd_wdata, rsp_ready,
      output cmd_ready, rsp_valid, rsp_rdata
   );

endinterface

// File: rtl/dap_bit_shifter.sv
// Serial SWDIO bit engine: shifts 1..MAX_BITS bits LSB-first out, or samples them in,
// paced by the baud generator's sclk_pulse (bit edge) and sclk_delay_pulse (sample strobe).
module dap_bit_shifter import dap_pkg::*; #(
   parameter int MAX_BITS = DEFAULT_MAX_BITS,
   parameter int CNT_W    = $clog2(MAX_BITS + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sclk_pulse,
   input  logic              sclk_delay_pulse,
   input  logic              abort,
   input  logic              swdio_in,
   dap_bit_shifter_if.slave  bus,
   output logic              swdio_out,
   output logic              swdio_oe,
   output logic              busy
);

   state_t              state, state_nxt;
   logic [MAX_BITS-1:0] shreg, shreg_nxt;
   logic [CNT_W-1:0]    len, len_sat;
   logic [CNT_W-1:0]    pulse_cnt, pulse_nxt;
   logic [CNT_W-1:0]    samp_cnt, samp_nxt;
   logic                dir;
   logic                accept, pulse_inc, samp_inc, finish;

   assign bus.cmd_ready = (state == IDLE);
   assign busy          = (state != IDLE);
   assign len_sat       = (bus.cmd_len > CNT_W'(MAX_BITS)) ? CNT_W'(MAX_BITS) : bus.cmd_len;

   // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      pulse_inc = 1'b0;
      samp_inc  = 1'b0;
      finish    = 1'b0;
      pulse_nxt = pulse_cnt;
      samp_nxt  = samp_cnt;
      unique case (state)
         IDLE: begin
            if (bus.cmd_valid) begin
               accept    = 1'b1;
               state_nxt = (bus.cmd_len == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            pulse_inc = sclk_pulse && (pulse_cnt < len);
            pulse_nxt = pulse_cnt + CNT_W'(pulse_inc);
            // Compare against the post-increment count so a zero-delay strobe samples this bit.
            samp_inc  = sclk_delay_pulse && (samp_cnt < pulse_nxt);
            samp_nxt  = samp_cnt + CNT_W'(samp_inc);
            if (pulse_nxt == len && samp_nxt == len) begin
               finish    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (bus.rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (abort) begin
         state_nxt = IDLE;
         accept    = 1'b0;
         pulse_inc = 1'b0;
         samp_inc  = 1'b0;
         finish    = 1'b0;
         pulse_nxt = pulse_cnt;
         samp_nxt  = samp_cnt;
      end
   end

   always_comb begin
      shreg_nxt = shreg;
      if (pulse_inc && dir == DIR_OUT) shreg_nxt = shreg >> 1;
      if (samp_inc && dir == DIR_IN)   shreg_nxt = {swdio_in, shreg[MAX_BITS-1:1]};
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: the shift register is cleared on reset too; it is a single register, not a memory array.
   always_ff @(posedge clk) begin
      if (reset) begin
         shreg         <= '0;
         len           <= '0;
         dir           <= DIR_IN;
         pulse_cnt     <= '0;
         samp_cnt      <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         swdio_out     <= 1'b0;
         swdio_oe      <= 1'b0;
      end else if (abort) begin
         pulse_cnt     <= '0;
         samp_cnt      <= '0;
         bus.rsp_valid <= 1'b0;
         swdio_oe      <= 1'b0;
      end else if (accept) begin
         shreg     <= bus.cmd_wdata;
         len       <= len_sat;
         dir       <= bus.cmd_dir;
         pulse_cnt <= '0;
         samp_cnt  <= '0;
         swdio_oe  <= (bus.cmd_dir == DIR_OUT);
         if (bus.cmd_dir == DIR_OUT) swdio_out <= bus.cmd_wdata[0];
         if (bus.cmd_len == '0) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= '0;
         end
      end else begin
         shreg     <= shreg_nxt;
         pulse_cnt <= pulse_nxt;
         samp_cnt  <= samp_nxt;
         // The final bit stays on the line after its edge instead of exposing stale shifter bits.
         if (pulse_inc && dir == DIR_OUT && pulse_nxt < len) swdio_out <= shreg_nxt[0];
         if (finish) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= (dir == DIR_IN) ? (shreg_nxt >> (CNT_W'(MAX_BITS) - len)) : '0;
         end else if (state == DONE && bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dap_bit_shifter.sv
// Directed bench for dap_bit_shifter: vector table of transfers plus abort/reset/empty sequences.
module tb_dap_bit_shifter;
   import dap_pkg::*;

   localparam int MB = DEFAULT_MAX_BITS;
   localparam int CW = $clog2(MB + 1);

   logic clk = 1'b0;
   logic reset, sclk_pulse, sclk_delay_pulse, abort, swdio_in;
   logic swdio_out, swdio_oe, busy;

   always #5 clk = ~clk;

   dap_bit_shifter_if #(.MAX_BITS(MB), .CNT_W(CW)) bus ();

   dap_bit_shifter #(.MAX_BITS(MB), .CNT_W(CW)) dut (
      .clk              (clk),
      .reset            (reset),
      .sclk_pulse       (sclk_pulse),
      .sclk_delay_pulse (sclk_delay_pulse),
      .abort            (abort),
      .swdio_in         (swdio_in),
      .bus              (bus),
      .swdio_out        (swdio_out),
      .swdio_oe         (swdio_oe),
      .busy             (busy)
   );

   typedef struct {
      string          name;
      logic           dir;
      logic [CW-1:0]  len;
      logic [31:0]    wdata;
      logic [31:0]    in_bits;
      int             div;
      int             dly;
      int             hold;
      logic [31:0]    exp_rdata;
      int             exp_bits;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;

   // Baud-generator model: pulse every div+1 clocks, strobe dly clocks later.
   logic        gen_en = 1'b0;
   int          gen_div = 0;
   int          gen_dly = 0;
   logic [31:0] in_bits = '0;
   int          pulse_idx = 0;
   int          strobe_idx = 0;
   logic        out_seq [64];
   logic        oe_seq  [64];

   initial begin
      int   div_cnt;
      logic p;
      logic [7:0] pipe;
      div_cnt = 0;
      pipe = '0;
      sclk_pulse = 1'b0;
      sclk_delay_pulse = 1'b0;
      swdio_in = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         p = 1'b0;
         if (gen_en) begin
            if (div_cnt >= gen_div) begin
               p = 1'b1;
               div_cnt = 0;
            end else begin
               div_cnt++;
            end
         end else begin
            div_cnt = 0;
         end
         pipe = {pipe[6:0], p};
         sclk_pulse = p;
         sclk_delay_pulse = pipe[gen_dly];
         if (p) begin
            if (pulse_idx < 64) begin
               out_seq[pulse_idx] = swdio_out;
               oe_seq[pulse_idx]  = swdio_oe;
            end
            pulse_idx++;
         end
         if (sclk_delay_pulse) begin
            swdio_in = (strobe_idx < 32) ? in_bits[strobe_idx] : 1'b0;
            strobe_idx++;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic send_cmd(input logic dir, input logic [CW-1:0] len, input logic [31:0] wdata,
                           input logic [31:0] ibits, input int div, input int dly);
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_dir   = dir;
      bus.cmd_len   = len;
      bus.cmd_wdata = wdata;
      in_bits    = ibits;
      gen_div    = div;
      gen_dly    = dly;
      pulse_idx  = 0;
      strobe_idx = 0;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      gen_en = 1'b1;
   endtask

   task automatic wait_rsp(input string name);
      int n;
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({name, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
   endtask

   task automatic wait_pulses(input int cnt, input string name);
      int n;
      n = 0;
      while (pulse_idx < cnt && n < 500) begin
         @(negedge clk);
         n++;
      end
      check({name, " pulses reached"}, 32'(pulse_idx >= cnt), 32'd1);
   endtask

   task automatic flush();
      gen_en = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   vec_t vecs [8];

   initial begin
      vec_t v;
      logic ok;
      vecs[0] = '{"out_a5",     DIR_OUT, 6'd8,  32'h0000_00A5, 32'h0,          2, 0, 0,  32'h0,          8};
      vecs[1] = '{"in_3",       DIR_IN,  6'd3,  32'h0,         32'h0000_0003,  2, 3, 0,  32'h0000_0003,  3};
      vecs[2] = '{"in_32_dly7", DIR_IN,  6'd32, 32'h0,         32'hDEAD_BEEF,  0, 7, 0,  32'hDEAD_BEEF, 32};
      vecs[3] = '{"in_16_hold", DIR_IN,  6'd16, 32'h0,         32'hFFFF_1234,  1, 2, 10, 32'h0000_1234, 16};
      vecs[4] = '{"out_32",     DIR_OUT, 6'd32, 32'h8000_0001, 32'h0,          0, 7, 0,  32'h0,         32};
      vecs[5] = '{"in_1",       DIR_IN,  6'd1,  32'h0,         32'h0000_0001,  3, 0, 0,  32'h0000_0001,  1};
      vecs[6] = '{"out_sat",    DIR_OUT, 6'd63, 32'h0F0F_00FF, 32'h0,          1, 4, 10, 32'h0,         32};
      vecs[7] = '{"in_sat",     DIR_IN,  6'd40, 32'h0,         32'hCAFE_F00D,  0, 1, 0,  32'hCAFE_F00D, 32};

      reset = 1'b1;
      abort = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_dir   = DIR_IN;
      bus.cmd_len   = '0;
      bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("reset rsp_rdata", bus.rsp_rdata, 32'd0);
      check("reset swdio_out", 32'(swdio_out), 32'd0);
      check("reset swdio_oe",  32'(swdio_oe), 32'd0);
      check("reset busy",      32'(busy), 32'd0);

      for (int i = 0; i < 8; i++) begin
         v = vecs[i];
         send_cmd(v.dir, v.len, v.wdata, v.in_bits, v.div, v.dly);
         check({v.name, " busy"}, 32'(busy), 32'd1);
         wait_rsp(v.name);
         if (v.hold > 0) begin
            ok = 1'b1;
            repeat (v.hold) begin
               @(negedge clk);
               if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== v.exp_rdata || bus.cmd_ready !== 1'b0)
                  ok = 1'b0;
            end
            check({v.name, " hold stable"}, 32'(ok), 32'd1);
         end
         gen_en = 1'b0;
         check({v.name, " rdata"}, bus.rsp_rdata, v.exp_rdata);
         check({v.name, " oe"}, 32'(swdio_oe), 32'(v.dir));
         check({v.name, " cmd_ready in DONE"}, 32'(bus.cmd_ready), 32'd0);
         ok = (pulse_idx >= v.exp_bits);
         for (int k = 0; k < v.exp_bits; k++) begin
            if (oe_seq[k] !== v.dir) ok = 1'b0;
            if (v.dir == DIR_OUT && out_seq[k] !== v.wdata[k]) ok = 1'b0;
         end
         check({v.name, " line sequence"}, 32'(ok), 32'd1);
         bus.rsp_ready = 1'b1;
         @(negedge clk);
         bus.rsp_ready = 1'b0;
         check({v.name, " released"}, {29'd0, bus.rsp_valid, busy, bus.cmd_ready}, 32'd1);
         if (v.dir == DIR_OUT) begin
            check({v.name, " last bit held"}, 32'(swdio_out), 32'(v.wdata[v.exp_bits-1]));
            check({v.name, " oe held in IDLE"}, 32'(swdio_oe), 32'd1);
         end
         flush();
      end

      // Empty transfer: response one clock after accept, pulses ignored, old rdata replaced.
      send_cmd(DIR_IN, 6'd0, 32'h0, 32'hFFFF_FFFF, 0, 0);
      check("len0 rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("len0 rdata", bus.rsp_rdata, 32'd0);
      ok = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (bus.rsp_valid !== 1'b1 || swdio_oe !== 1'b0 || bus.rsp_rdata !== 32'd0) ok = 1'b0;
      end
      check("len0 pulses ignored", 32'(ok), 32'd1);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check("len0 released busy", 32'(busy), 32'd0);
      flush();

      // Abort in IDLE beats a simultaneous command.
      bus.cmd_valid = 1'b1;
      bus.cmd_dir   = DIR_OUT;
      bus.cmd_len   = 6'd4;
      bus.cmd_wdata = 32'hF;
      abort = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      abort = 1'b0;
      check("abort idle cmd not taken", {30'd0, busy, swdio_oe}, 32'd0);

      // Abort during bit 5 of a 16-bit OUT, with a new command offered in the same cycle.
      send_cmd(DIR_OUT, 6'd16, 32'h0000_FFFF, 32'h0, 1, 0);
      wait_pulses(5, "abort16");
      check("abort16 active", {30'd0, busy, swdio_oe}, 32'd3);
      bus.cmd_valid = 1'b1;
      bus.cmd_dir   = DIR_IN;
      bus.cmd_len   = 6'd4;
      abort = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      abort = 1'b0;
      gen_en = 1'b0;
      check("abort16 state", {28'd0, busy, swdio_oe, bus.rsp_valid, bus.cmd_ready}, 32'd1);
      ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
      end
      check("abort16 no response", 32'(ok), 32'd1);

      // Reset mid-transfer returns everything to reset values with no response.
      send_cmd(DIR_OUT, 6'd8, 32'h0000_00FF, 32'h0, 1, 0);
      wait_pulses(3, "reset_mid");
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      gen_en = 1'b0;
      check("reset_mid outputs",
            {26'd0, busy, swdio_oe, swdio_out, bus.rsp_valid, bus.cmd_ready, 1'b0}, 32'd2);
      check("reset_mid rdata", bus.rsp_rdata, 32'd0);
      ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
      end
      check("reset_mid no response", 32'(ok), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
